concat_lane_arbiter: RTL and testbench
======================================

// Module: concat_lane_arbiter
// PURPOSE
//   Round-robin arbiter that shares one WIDTH-bit concatenation lane among NREQ requesters.
//   Each requester drives a nibble slice of the flattened data_in bus; the owner's slice is
//   registered onto out_data. Sits in front of the nibble pass-through/concatenation datapath
//   and sequences bursts so no single requester holds the lane beyond MAX_HOLD beats.
// PARAMETERS
//   NREQ      4   number of requesters (>=2)
//   WIDTH     4   lane width in bits
//   MAX_HOLD  3   max beats per grant before forced release (>=1)
// PORTS
//   clk       in   1            single clock, rising edge
//   rst_n     in   1            asynchronous, active-low reset
//   req       in   NREQ         request / beat-valid per requester
//   last      in   NREQ         final beat of requester's burst (sampled with req)
//   data_in   in   NREQ*WIDTH   requester i slice = data_in[i*WIDTH +: WIDTH] (req 0 at LSBs)
//   grant     out  NREQ         one-hot lane ownership, registered
//   busy      out  1            lane owned (state OWNED)
//   out_valid out  1            out_data holds a beat accepted last cycle
//   out_data  out  WIDTH        owner's slice, registered
//   out_src   out  SRC_W        index of requester that produced out_data
//   timeout   out  1            1-cycle pulse: grant released by MAX_HOLD limit
// BEHAVIOUR
//   Reset (rst_n=0, async): state IDLE, ptr=0, hold_cnt=0, all outputs 0.
//   States: IDLE, OWNED.
//   IDLE: if |req, winner = first i with req[i], scanning ptr, ptr+1, ... mod NREQ;
//     next edge: grant=onehot(winner), owner=winner, hold_cnt=0, busy=1, -> OWNED.
//     Request-to-grant latency 1 cycle; no beat is accepted in IDLE.
//   OWNED, each edge:
//     beat = req[owner]; if beat: out_valid=1, out_data=slice(owner), out_src=owner,
//       hold_cnt++. Else out_valid=0 (out_data/out_src hold previous value).
//     release if (beat & last[owner]) | ~req[owner] | (beat & hold_cnt==MAX_HOLD-1).
//     On release: grant=0, busy=0, ptr=(owner+1) mod NREQ, -> IDLE.
//     timeout=1 only when release is caused solely by the MAX_HOLD limit (not last).
//   One dead cycle (IDLE) between consecutive owners; max throughput MAX_HOLD/(MAX_HOLD+1).
//   Non-owner req/last/data ignored while OWNED; requests not queued, just re-sampled in IDLE.
//   last with req low is ignored. Beat and last on same edge as limit: counts as last, no timeout.
//   Owner drops req mid-burst: release same edge, no beat, no timeout.
//   ptr wraps NREQ-1 -> 0. hold_cnt width $clog2(MAX_HOLD+1); never exceeds MAX_HOLD.
//   out_valid only asserted the cycle after an accepted beat; deasserts in IDLE.
// STRUCTURE
//   Package concat_arb_pkg: state enum {IDLE, OWNED}, SRC_W = $clog2(NREQ) localparam helper.
//   Sub-module rr_pick: combinational rotating-priority encoder (req, ptr -> idx, found).
//   Top: FSM, ptr, owner/hold_cnt registers, output registers, slice mux.
// TESTING
//   1 Reset mid-burst: rst_n low while OWNED -> grant=0, busy=0, out_valid=0 immediately; ptr=0.
//   2 req=4'b0001, data_in=16'h000A, last on 2nd beat -> grant=0001 after 1 cycle; out_data A,A
//     with out_src=0; release, ptr=1, timeout=0.
//   3 req=4'b1111 held, last=0, MAX_HOLD=3 -> owners 0,1,2,3,0 in order; each 3 beats then
//     timeout pulse; 1 idle cycle between grants.
//   4 ptr=3, req=4'b1001 -> grant=1000 first, then ptr wraps to 0 and grant=0001.
//   5 Owner 2 (data_in[11:8]=4'hE) drops req after 1 beat -> one beat out_data=E, out_src=2;
//     release on drop edge, no timeout, ptr=3.
//   6 Beat with last on MAX_HOLD-th beat -> release, timeout=0; non-owner data changes
//     during OWNED never appear on out_data.

Source files
------------

// File: rtl/concat_arb_pkg.sv
// ============================================================================
// concat_arb_pkg: shared FSM state type and width helper for the lane arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package concat_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// rr_pick: rotating-priority encoder, first asserted request at or after ptr
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick
  import concat_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]             req_i,
  input  logic [src_width(NREQ)-1:0]  ptr_i,
  output logic [src_width(NREQ)-1:0]  idx_o,
  output logic                        found_o
);

  localparam int SRC_W = src_width(NREQ);

  int pos;

  // Scan from the farthest offset down so the offset closest to ptr wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = int'(ptr_i) + k;
      if (pos >= NREQ) begin
        pos = pos - NREQ;
      end
      if (req_i[pos]) begin
        idx_o   = SRC_W'(pos);
        found_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/concat_lane_arbiter.sv
// ============================================================================
// concat_lane_arbiter: round-robin owner of one WIDTH-bit lane, bursts capped
// at MAX_HOLD beats.  Revision: 1.0
// ============================================================================
`default_nettype none

module concat_lane_arbiter
  import concat_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ-1:0]             last,
  input  logic [NREQ*WIDTH-1:0]       data_in,
  output logic [NREQ-1:0]             grant,
  output logic                        busy,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic [src_width(NREQ)-1:0]  out_src,
  output logic                        timeout
);

  localparam int SRC_W  = src_width(NREQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   ptr_q, ptr_d;
  logic [SRC_W-1:0]   owner_q, owner_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SRC_W-1:0]   out_src_q, out_src_d;
  logic               timeout_q, timeout_d;

  logic [SRC_W-1:0]   pick_idx;
  logic               pick_found;
  logic               beat;
  logic               owner_last;
  logic               at_limit;
  logic [WIDTH-1:0]   owner_slice;
  logic [SRC_W-1:0]   owner_next;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign beat        = req[owner_q];
  assign owner_last  = last[owner_q];
  assign at_limit    = (hold_q == HOLD_W'(MAX_HOLD - 1));
  assign owner_slice = data_in[int'(owner_q)*WIDTH +: WIDTH];
  assign owner_next  = (owner_q == SRC_W'(NREQ - 1)) ? '0 : owner_q + SRC_W'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    hold_d      = hold_q;
    grant_d     = grant_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = OWNED;
          owner_d = pick_idx;
          hold_d  = '0;
          grant_d = NREQ'(1) << pick_idx;
        end
      end
      OWNED: begin
        if (beat) begin
          out_valid_d = 1'b1;
          out_data_d  = owner_slice;
          out_src_d   = owner_q;
          hold_d      = hold_q + HOLD_W'(1);
        end
        // A last beat that coincides with the hold limit is a normal end, not a timeout.
        if (!beat || owner_last || at_limit) begin
          state_d   = IDLE;
          grant_d   = '0;
          hold_d    = '0;
          ptr_d     = owner_next;
          timeout_d = beat && at_limit && !owner_last;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      hold_q      <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      hold_q      <= hold_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q == OWNED);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign timeout   = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_concat_lane_arbiter.sv
// ============================================================================
// tb_concat_lane_arbiter: directed vectors for the round-robin lane arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_concat_lane_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 3;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   last;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic [1:0]        out_src;
  logic              timeout;

  int checks   = 0;
  int failures = 0;

  concat_lane_arbiter #(
    .NREQ     (NREQ),
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .data_in   (data_in),
    .grant     (grant),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    last    = '0;
    data_in = '0;
    #23;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    rst_n = 1'b1;

    // Single requester 0, last on second beat
    req = 4'b0001; data_in = 16'h000A;
    tick();
    chk("t2_grant", 32'(grant), 32'h1);
    chk("t2_busy", 32'(busy), 32'h1);
    chk("t2_nobeat_idle", 32'(out_valid), 32'h0);
    tick();
    chk("t2_b1_valid", 32'(out_valid), 32'h1);
    chk("t2_b1_data", 32'(out_data), 32'hA);
    chk("t2_b1_src", 32'(out_src), 32'h0);
    chk("t2_b1_grant", 32'(grant), 32'h1);
    last = 4'b0001;
    tick();
    chk("t2_b2_data", 32'(out_data), 32'hA);
    chk("t2_b2_valid", 32'(out_valid), 32'h1);
    chk("t2_rel_grant", 32'(grant), 32'h0);
    chk("t2_rel_busy", 32'(busy), 32'h0);
    chk("t2_timeout", 32'(timeout), 32'h0);

    // ptr is now 1: requester 1 must beat requester 0
    req = 4'b0011; last = 4'b0000; data_in = 16'h0050;
    tick();
    chk("ptr1_grant", 32'(grant), 32'h2);
    chk("ptr1_valid", 32'(out_valid), 32'h0);
    req = 4'b0000;
    tick();
    chk("drop0_grant", 32'(grant), 32'h0);
    chk("drop0_valid", 32'(out_valid), 32'h0);
    chk("drop0_timeout", 32'(timeout), 32'h0);

    // Owner 2 drops after one beat
    req = 4'b0100; data_in = 16'h0E00;
    tick();
    chk("t5_grant", 32'(grant), 32'h4);
    tick();
    chk("t5_valid", 32'(out_valid), 32'h1);
    chk("t5_data", 32'(out_data), 32'hE);
    chk("t5_src", 32'(out_src), 32'h2);
    req = 4'b0000;
    tick();
    chk("t5_rel_grant", 32'(grant), 32'h0);
    chk("t5_rel_valid", 32'(out_valid), 32'h0);
    chk("t5_rel_timeout", 32'(timeout), 32'h0);
    chk("t5_hold_data", 32'(out_data), 32'hE);
    chk("t5_hold_src", 32'(out_src), 32'h2);

    // ptr=3, req 1001: owner 3 then wrap to owner 0
    req = 4'b1001; last = 4'b1001; data_in = 16'h7008;
    tick();
    chk("t4_grant3", 32'(grant), 32'h8);
    tick();
    chk("t4_data3", 32'(out_data), 32'h7);
    chk("t4_src3", 32'(out_src), 32'h3);
    chk("t4_rel3", 32'(grant), 32'h0);
    tick();
    chk("t4_grant0", 32'(grant), 32'h1);
    chk("t4_idle_valid", 32'(out_valid), 32'h0);
    tick();
    chk("t4_data0", 32'(out_data), 32'h8);
    chk("t4_src0", 32'(out_src), 32'h0);
    chk("t4_rel0", 32'(grant), 32'h0);
    req = 4'b0000; last = 4'b0000;
    tick();
    chk("t4_idle_grant", 32'(grant), 32'h0);

    // Reset in the middle of a burst by requester 1
    req = 4'b0010; data_in = 16'h0030;
    tick();
    chk("t1_grant", 32'(grant), 32'h2);
    tick();
    chk("t1_valid", 32'(out_valid), 32'h1);
    req = 4'b0000;
    rst_n = 1'b0;
    #2;
    chk("t1_rst_grant", 32'(grant), 32'h0);
    chk("t1_rst_busy", 32'(busy), 32'h0);
    chk("t1_rst_valid", 32'(out_valid), 32'h0);
    chk("t1_rst_data", 32'(out_data), 32'h0);
    tick();
    rst_n = 1'b1;

    // All requesting, no last: rotation 0,1,2,3,0 with 3-beat timeouts
    req = 4'b1111; last = 4'b0000; data_in = 16'h4321;
    for (int k = 0; k < 5; k++) begin
      int o;
      o = k % 4;
      tick();
      chk($sformatf("t3_grant_k%0d", k), 32'(grant), 32'(1 << o));
      chk($sformatf("t3_gap_valid_k%0d", k), 32'(out_valid), 32'h0);
      chk($sformatf("t3_gap_to_k%0d", k), 32'(timeout), 32'h0);
      for (int b = 1; b <= MAX_HOLD; b++) begin
        tick();
        chk($sformatf("t3_valid_k%0d_b%0d", k, b), 32'(out_valid), 32'h1);
        chk($sformatf("t3_data_k%0d_b%0d", k, b), 32'(out_data), 32'(o + 1));
        chk($sformatf("t3_src_k%0d_b%0d", k, b), 32'(out_src), 32'(o));
        chk($sformatf("t3_grant_k%0d_b%0d", k, b), 32'(grant), (b == MAX_HOLD) ? 32'h0 : 32'(1 << o));
        chk($sformatf("t3_to_k%0d_b%0d", k, b), 32'(timeout), (b == MAX_HOLD) ? 32'h1 : 32'h0);
      end
    end

    // ptr=1: last on MAX_HOLD-th beat, non-owner data churn
    req = 4'b0010; last = 4'b0000; data_in = 16'h0090;
    tick();
    chk("t6_grant", 32'(grant), 32'h2);
    tick();
    chk("t6_b1_data", 32'(out_data), 32'h9);
    data_in = 16'hFF9F;
    tick();
    chk("t6_b2_data", 32'(out_data), 32'h9);
    chk("t6_b2_grant", 32'(grant), 32'h2);
    last = 4'b0010; data_in = 16'h5A96;
    tick();
    chk("t6_b3_data", 32'(out_data), 32'h9);
    chk("t6_b3_valid", 32'(out_valid), 32'h1);
    chk("t6_rel_grant", 32'(grant), 32'h0);
    chk("t6_timeout", 32'(timeout), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    req = 4'b0000; last = 4'b0000;
    tick();
    chk("t6_idle_valid", 32'(out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
